// File: rtl/bf_feistel_sbox_unit.sv
// bf_feistel_sbox_unit: writable four-S-box Blowfish F unit, 2-stage valid/ready pipeline with zero-fill sequencer
// Ports: clk/rst (sync, active high); wr_en/wr_box/wr_idx/wr_data load one entry;
// clr_start/busy/clr_done run the zero-fill; in_valid/in_ready/in_x = {a,b,c,d} lookup request;
// out_valid/out_ready/out_f = ((S0[a]+S1[b])^S2[c])+S3[d].
module bf_feistel_sbox_unit #(
  parameter int WORD_W = 32,
  parameter int IDX_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [1:0]           wr_box,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [WORD_W-1:0]    wr_data,
  input  logic                 clr_start,
  output logic                 busy,
  output logic                 clr_done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*IDX_W-1:0]   in_x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_W-1:0]    out_f
);
  localparam int DEPTH = 1 << IDX_W;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_n;
  logic [IDX_W-1:0] cnt, cnt_n;
  logic [WORD_W-1:0] mem [4][DEPTH];
  logic [WORD_W-1:0] rd [4];
  logic [WORD_W-1:0] f;
  logic v1, adv, accept;
  assign adv      = !out_valid | out_ready;
  assign in_ready = (state == IDLE) & adv;
  assign accept   = in_valid & in_ready;
  assign busy     = state == CLEAR;
  assign clr_done = busy & (&cnt);
  assign f        = ((rd[0] + rd[1]) ^ rd[2]) + rd[3];
  always_comb begin
    state_n = (state == IDLE) ? (clr_start ? CLEAR : IDLE) : ((&cnt) ? IDLE : CLEAR);
    cnt_n   = busy ? cnt + 1'b1 : '0;
  end
  // Reads launch only on accept so stalled stage-1 data is never overwritten;
  // nonblocking semantics give read-before-write on a same-index collision.
  always_ff @(posedge clk) begin
    if (busy)
      for (int i = 0; i < 4; i++) mem[i][cnt] <= '0;
    else if (wr_en)
      mem[wr_box][wr_idx] <= wr_data;
    if (accept)
      for (int i = 0; i < 4; i++) rd[i] <= mem[i][in_x[(3-i)*IDX_W +: IDX_W]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      v1        <= 1'b0;
      out_valid <= 1'b0;
      out_f     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (adv) begin
        v1        <= accept;
        out_valid <= v1;
        if (v1) out_f <= f;
      end
    end
  end
endmodule

// File: tb/tb_bf_feistel_sbox_unit.sv
// tb_bf_feistel_sbox_unit: directed table-driven bench for bf_feistel_sbox_unit
module tb_bf_feistel_sbox_unit;
  logic clk = 0, rst = 1, wr_en = 0, clr_start = 0, in_valid = 0, out_ready = 1;
  logic [1:0] wr_box = 0;
  logic [7:0] wr_idx = 0;
  logic [31:0] wr_data = 0, in_x = 0;
  logic busy, clr_done, in_ready, out_valid;
  logic [31:0] out_f;
  int n_chk = 0, n_fail = 0;
  bf_feistel_sbox_unit #(.WORD_W(32), .IDX_W(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_box(wr_box), .wr_idx(wr_idx), .wr_data(wr_data),
    .clr_start(clr_start), .busy(busy), .clr_done(clr_done), .in_valid(in_valid),
    .in_ready(in_ready), .in_x(in_x), .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f)
  );
  always #5 clk = ~clk;
  typedef struct { logic [1:0] b; logic [7:0] i; logic [31:0] d; } ld_t;
  typedef struct { string nm; logic [31:0] x; logic [31:0] f; } vec_t;
  ld_t ld [10];
  vec_t vt [4];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic wr(input logic [1:0] b, input logic [7:0] i, input logic [31:0] d);
    wr_en = 1; wr_box = b; wr_idx = i; wr_data = d;
    tick();
    wr_en = 0;
  endtask
  // Present one lookup with out_ready=1; any wr_en already set by the caller shares the accept cycle.
  task automatic lookup(input string nm, input logic [31:0] x, input logic [31:0] exp);
    in_valid = 1; in_x = x; out_ready = 1;
    #1;
    chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 0; wr_en = 0;
    chk({nm, " valid_early"}, 32'(out_valid), 32'd0);
    tick();
    chk({nm, " out_valid"}, 32'(out_valid), 32'd1);
    chk({nm, " out_f"}, out_f, exp);
    tick();
  endtask
  initial begin
    int sent, rx, nb, nd, dpos, inr, c;
    ld = '{'{0, 8'h00, 32'hd1310ba6}, '{1, 8'h01, 32'h98dfb5ac}, '{2, 8'h02, 32'h2ffd72db},
           '{3, 8'h03, 32'hd01adfb7}, '{0, 8'hff, 32'hffffffff}, '{1, 8'hff, 32'h00000001},
           '{2, 8'hff, 32'h00000000}, '{3, 8'hff, 32'hffffffff}, '{1, 8'h05, 32'h11111111},
           '{0, 8'h10, 32'hdeadbeef}};
    vt = '{'{"directed", 32'h00010203, 32'h16089340}, '{"wrap", 32'hffffffff, 32'hffffffff},
           '{"mix_a", 32'h00ff02ff, 32'hfecc797b}, '{"mix_b", 32'hff01ff03, 32'h68fa9562}};
    tick(); tick();
    chk("rst busy", 32'(busy), 0);
    chk("rst clr_done", 32'(clr_done), 0);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_f", out_f, 0);
    rst = 0;
    for (int i = 0; i < 10; i++) wr(ld[i].b, ld[i].i, ld[i].d);
    for (int i = 0; i < 4; i++) lookup(vt[i].nm, vt[i].x, vt[i].f);
    // Four back-to-back lookups with out_ready low for cycles 2..6.
    sent = 0; rx = 0;
    for (c = 0; c < 40 && rx < 4; c++) begin
      out_ready = !(c >= 2 && c < 7);
      in_valid = sent < 4;
      in_x = vt[sent < 4 ? sent : 0].x;
      #1;
      if (out_valid && !out_ready) begin
        chk("stall in_ready", 32'(in_ready), 0);
        chk("stall hold out_f", out_f, vt[rx].f);
      end
      if (out_valid && out_ready) begin
        chk("stream order", out_f, vt[rx].f);
        rx++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 0; out_ready = 1;
    chk("stream count", 32'(rx), 4);
    tick(); tick();
    chk("stream no dup", 32'(out_valid), 0);
    // Same-cycle write to S1[05] and lookup reading it sees the old value.
    wr_en = 1; wr_box = 1; wr_idx = 8'h05; wr_data = 32'h22222222;
    lookup("collide_old", 32'h00050203, 32'h9dda4e23);
    lookup("collide_new", 32'h00050203, 32'hacc93eca);
    // Full clear with a write attempt in the middle.
    clr_start = 1; tick(); clr_start = 0;
    nb = 0; nd = 0; dpos = 0; inr = 0;
    while (busy && nb < 300) begin
      nb++;
      if (clr_done) begin nd++; dpos = nb; end
      if (in_ready) inr++;
      if (nb == 50) begin wr_en = 1; wr_box = 0; wr_idx = 8'h10; wr_data = 32'hcafef00d; end
      tick();
      wr_en = 0;
    end
    chk("clear busy cycles", 32'(nb), 256);
    chk("clear done count", 32'(nd), 1);
    chk("clear done pos", 32'(dpos), 256);
    chk("clear in_ready", 32'(inr), 0);
    lookup("clr_a", 32'h00010203, 0);
    lookup("clr_b", 32'hffffffff, 0);
    lookup("clr_wr_ignored", 32'h10101010, 0);
    // Reset in the middle of a second clear.
    for (int b = 0; b < 4; b++) wr(2'(b), 8'h10, 32'h12345678);
    wr(0, 8'h80, 32'h80000000); wr(1, 8'h80, 32'h80000001);
    wr(2, 8'h80, 32'h0000ffff); wr(3, 8'h80, 32'h00000003);
    lookup("pre_80", 32'h80808080, 32'h00010001);
    clr_start = 1; tick(); clr_start = 0;
    nb = 0; nd = 0;
    while (busy && nb < 300) begin
      nb++;
      if (clr_done) nd++;
      if (nb == 100) rst = 1;
      tick();
      rst = 0;
    end
    chk("rstclr at", 32'(nb), 100);
    chk("rstclr busy", 32'(busy), 0);
    chk("rstclr out_valid", 32'(out_valid), 0);
    chk("rstclr no done", 32'(nd), 0);
    lookup("rstclr_10", 32'h10101010, 0);
    lookup("rstclr_80", 32'h80808080, 32'h00010001);
    // Reset with a lookup in flight discards it.
    in_valid = 1; in_x = 32'h80808080; tick(); in_valid = 0;
    rst = 1; tick(); rst = 0;
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) nd++;
      tick();
    end
    chk("rst flush", 32'(nd), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
